mat_deser: RTL and testbench
============================

# mat_deser

Serial-to-matrix deserializer: accepts fixed-point elements one per handshake in row-major order and assembles them into a ROWS x COLS matrix, presented on a held, packed output bus with valid/ready. Sits directly upstream of the combinational transpose and other matrix operators, bridging element streams from memories or DMA into the whole-matrix ports the library's operators consume.

## Interface
Parameters:
- ROWS, 3, rows of assembled matrix (>=1)
- COLS, 2, columns of assembled matrix (>=1)

Ports:
- g.clk  input  1  clock, carried in the fixedp interface port g
- g.reset  input  1  reset, carried in g; asynchronous, active-high
- g  interface  fixedp  fixed-point parameters (g.WIDTH) and common ports
- in_data  input  g.WIDTH  element, row-major order: (1,1),(1,2)..(1,COLS),(2,1)..
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept an element
- f  output  [ROWS:1][COLS:1][g.WIDTH-1:0]  assembled matrix, stable while out_valid=1
- out_valid  output  1  f holds a complete matrix
- out_ready  input  1  consumer takes f

## Operation
- Accept when in_valid && in_ready. Write in_data to the element at (row, col), then advance col; at col==COLS, set col=1 and advance row; at (ROWS, COLS), set row=col=1 and the matrix is complete.
- Row and col counters are 1-based, $clog2(max+1) bits wide. Elements are stored verbatim; there is no arithmetic or rescaling.
- State machine:
  - FILL: in_ready=1, out_valid=0. Accepting element (ROWS,COLS) moves to FULL.
  - FULL: out_valid=1, in_ready=0 (single-buffer build). out_valid && out_ready moves to FILL.
- f changes only on accepted writes in FILL. In FULL, f is frozen.
- ROWS*COLS==1: every accepted element completes a matrix.
- Reset mid-fill discards the partial matrix. Counters return to (1,1) and the state returns to FILL.

## Timing
- Reset values: state=FILL, row=col=1, f=all zeros, out_valid=0, in_ready=0 while g.reset is asserted and 1 in the first cycle after deassertion.
- Latency: the last element is accepted at clock edge N, and out_valid=1 with complete f is visible after edge N.
- Throughput, single-buffer: ROWS*COLS+1 cycles per matrix minimum, because of one bubble in FULL.
- in_ready does not depend combinationally on in_valid. out_valid does not depend on out_ready.
- in_valid=1 with in_ready=0 has no effect, and the element is not consumed.

## Configuration
- Macro MAT_DESER_DBUF_EN.
- Undefined: behaviour is single-buffered as above.
- Defined: a second, shadow matrix register is added.
  - Writes always target the shadow register.
  - in_ready=1 unless the shadow is complete and f is still held (out_valid && !out_ready).
  - When the shadow completes:
    - If FULL is not occupied, or is being released in the same cycle (out_ready=1), the shadow is copied into f and out_valid is 1 on the next cycle. A simultaneous release and completion keeps out_valid=1 with the new matrix; there is no bubble.
    - Otherwise the shadow waits. in_ready drops until out_ready, and the copy happens on that handshake.
  - Sustained throughput is one matrix per ROWS*COLS cycles.
  - Reset clears both registers.

## Test plan
- Reset: assert g.reset mid-cycle with in_valid=1. Required: out_valid=0, f=0, and in_ready=0 immediately (asynchronous). After release, in_ready=1 and the next element lands at (1,1).
- Fill, ROWS=3, COLS=2, WIDTH=16: feed 1..6 continuously with out_ready=0. Required: f[1][1]=1, f[1][2]=2, f[2][1]=3, f[3][2]=6; out_valid rises one cycle after the 6th accept; in_ready=0 while held, in single-buffer build.
- Backpressure: hold out_ready=0 for 10 cycles, then 1. Required: f unchanged for all 10 cycles, and one handshake returns the block to FILL with in_ready=1 the following cycle.
- Stalled input: toggle in_valid 1,0,0,1 with values 0xAAAA, 0x5555. Required: only the 0xAAAA and 0x5555 beats are stored, at (1,1) and (1,2).
- Reset mid-fill: reset after 4 accepts, then feed 10..15. Required: f = 10..15 row-major, with no remnants of the first partial matrix.
- DBUF build: out_ready=1 and continuous input of 12 elements. Required: two matrices, out_valid pulses at accepts 6 and 12 with no in_ready gaps. With out_ready=0, in_ready falls after the 12th accept and recovers one cycle after out_ready=1.

Source files
------------

// File: rtl/mat_deser_if.sv
// fixedp: common clock/reset bundle shared by the fixed-point matrix operators.
// WIDTH is the element width; the consuming block's WIDTH must match it.
interface fixedp #(
  parameter int WIDTH = 16
) ();
  typedef logic [WIDTH-1:0] elem_t;

  logic clk;
  logic reset;

  modport master (output clk, output reset);
  modport slave  (input  clk, input  reset);
endinterface

// File: rtl/mat_deser.sv
// mat_deser: row-major element stream -> held ROWS x COLS matrix with valid/ready.
// Define MAT_DESER_DBUF_EN to add a shadow matrix that removes the per-matrix bubble.
//
// Handshakes: a beat transfers on a rising edge where valid && ready. in_ready is
// never a function of in_valid, and out_valid is never a function of out_ready.
module mat_deser #(
  parameter int ROWS  = 3,
  parameter int COLS  = 2,
  parameter int WIDTH = 16
) (
  fixedp.slave                              g,
  input  logic [WIDTH-1:0]                  in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [ROWS:1][COLS:1][WIDTH-1:0]  f,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              dbg_state
);
  localparam int RW = $clog2(ROWS + 1);
  localparam int CW = $clog2(COLS + 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  state_t        state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          accept;
  logic          last;

  assign accept    = in_valid && in_ready;
  assign last      = (row == ROW_MAX) && (col == COL_MAX);
  assign dbg_state = (state == FULL);

  // 1-based write pointer; wraps to (1,1) when the last element is accepted.
  always_ff @(posedge g.clk or posedge g.reset) begin
    if (g.reset) begin
      row <= RW'(1);
      col <= CW'(1);
    end else if (accept) begin
      if (col == COL_MAX) begin
        col <= CW'(1);
        row <= (row == ROW_MAX) ? RW'(1) : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

`ifdef MAT_DESER_DBUF_EN
  logic [ROWS:1][COLS:1][WIDTH-1:0] sh;
  logic [ROWS:1][COLS:1][WIDTH-1:0] sh_nxt;
  logic                             sh_full;

  always_comb begin
    sh_nxt           = sh;
    sh_nxt[row][col] = in_data;
  end

  // Input stalls only while a completed shadow waits behind a held output.
  assign in_ready = !g.reset && !sh_full;

  always_ff @(posedge g.clk or posedge g.reset) begin
    if (g.reset) begin
      state     <= FILL;
      f         <= '0;
      out_valid <= 1'b0;
      sh        <= '0;
      sh_full   <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (sh_full) begin
          f       <= sh;
          sh_full <= 1'b0;
        end else begin
          state     <= FILL;
          out_valid <= 1'b0;
        end
      end
      // Completion wins over a same-cycle release so out_valid stays high.
      if (accept) begin
        sh <= sh_nxt;
        if (last) begin
          if (!out_valid || out_ready) begin
            f         <= sh_nxt;
            state     <= FULL;
            out_valid <= 1'b1;
          end else begin
            sh_full <= 1'b1;
          end
        end
      end
    end
  end
`else
  assign in_ready = !g.reset && (state == FILL);

  always_ff @(posedge g.clk or posedge g.reset) begin
    if (g.reset) begin
      state     <= FILL;
      f         <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            f[row][col] <= in_data;
            if (last) begin
              state     <= FULL;
              out_valid <= 1'b1;
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            state     <= FILL;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= FILL;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_mat_deser.sv
// Self-checking bench for mat_deser (ROWS=3, COLS=2, WIDTH=16), both buffer builds.
module tb_mat_deser;
  localparam int ROWS = 3;
  localparam int COLS = 2;
  localparam int W    = 16;
  localparam int MW   = ROWS * COLS * W;

  fixedp #(.WIDTH(W)) g ();

  logic [W-1:0]                 in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic [ROWS:1][COLS:1][W-1:0] f;
  logic                         out_valid;
  logic                         out_ready;
  logic                         dbg_state;

  mat_deser #(.ROWS(ROWS), .COLS(COLS), .WIDTH(W)) dut (
    .g         (g),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .f         (f),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial g.clk = 1'b0;
  always #5 g.clk = ~g.clk;

  // ---------------- scoreboard state ----------------
  logic [MW-1:0] exp_q[$];
  logic [MW-1:0] cur;
  logic [MW-1:0] last_mat;
  logic [MW-1:0] held;
  logic [MW-1:0] mb1;
  int            pos;
  int            n_checks;
  int            n_fail;
  int            n_pops;
  int            pops_before;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Element (r,c), 1-based, sits at flat offset ((r-1)*COLS + (c-1))*W.
  function automatic logic [MW-1:0] set_elem(input logic [MW-1:0] m, input int r, input int c,
                                             input logic [W-1:0] v);
    logic [MW-1:0] t;
    t = m;
    t[((r - 1) * COLS + (c - 1)) * W +: W] = v;
    return t;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] v);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = v;
    while (!in_ready && n < 50) begin
      @(negedge g.clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      @(negedge g.clk);
    end
  endtask

  task automatic feed(input logic [W-1:0] v);
    cur = set_elem(cur, pos / COLS + 1, pos % COLS + 1, v);
    pos++;
    if (pos == ROWS * COLS) begin
      exp_q.push_back(cur);
      last_mat = cur;
      cur      = '0;
      pos      = 0;
    end
    send(v);
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      in_data = W'($urandom_range(0, 16'hffff));
      @(negedge g.clk);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge g.clk);
      n++;
    end
    check("drain", 128'(exp_q.size()), 0);
  endtask

  task automatic report();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  // ---------------- output monitor ----------------
  always @(negedge g.clk) begin
    #2;
    if (!g.reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        check("matrix_out", f, exp_q.pop_front());
        n_pops++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    n_fail++;
    report();
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    n_pops    = 0;
    cur       = '0;
    last_mat  = '0;
    pos       = 0;
    g.reset   = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    repeat (2) @(negedge g.clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_f", f, 0);
    check("rst_state", dbg_state, 0);
    g.reset = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    @(negedge g.clk);

    // Fill 1..6 with the consumer stalled.
    for (int i = 1; i <= 6; i++) begin
      feed(W'(i));
      if (i < 6) check("fill_out_valid_low", out_valid, 0);
    end
    in_valid = 1'b0;
    check("fill_out_valid", out_valid, 1);
    check("fill_state", dbg_state, 1);
    check("f11", f[1][1], 1);
    check("f12", f[1][2], 2);
    check("f21", f[2][1], 3);
    check("f22", f[2][2], 4);
    check("f31", f[3][1], 5);
    check("f32", f[3][2], 6);
`ifdef MAT_DESER_DBUF_EN
    check("fill_in_ready", in_ready, 1);
`else
    check("fill_in_ready", in_ready, 0);
`endif

    // Backpressure: output frozen for 10 cycles, then one handshake.
    held = last_mat;
    for (int i = 0; i < 10; i++) begin
      in_data = W'($urandom_range(0, 16'hffff));
      @(negedge g.clk);
      check("hold_f", f, held);
      check("hold_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(negedge g.clk);
    out_ready = 1'b0;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    check("release_pops", 128'(n_pops), 1);

    // Stalled input: valid pattern 1,0,0,1.
    feed(16'hAAAA);
    idle_cycles(2);
    feed(16'h5555);
    in_valid = 1'b0;
`ifdef MAT_DESER_DBUF_EN
    check("stall_f_kept", f, held);
`else
    check("stall_f11", f[1][1], 16'hAAAA);
    check("stall_f12", f[1][2], 16'h5555);
    check("stall_f21_old", f[2][1], 3);
`endif
    for (int i = 0; i < 4; i++) feed(W'($urandom_range(0, 16'hffff)));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    out_ready = 1'b0;

    // Reset in the middle of a fill.
    for (int i = 0; i < 4; i++) feed(W'(16'h0100 + i));
    in_valid = 1'b1;
    in_data  = 16'h7777;
    #3;
    g.reset = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_f", f, 0);
    check("midrst_state", dbg_state, 0);
    @(negedge g.clk);
    in_valid = 1'b0;
    g.reset  = 1'b0;
    cur      = '0;
    pos      = 0;
    #1;
    check("midrst_release_in_ready", in_ready, 1);
    for (int i = 10; i <= 15; i++) feed(W'(i));
    in_valid = 1'b0;
    check("refill_f", f, last_mat);
    check("refill_f11", f[1][1], 10);
    check("refill_out_valid", out_valid, 1);
    out_ready = 1'b1;
    wait_drain();
    out_ready = 1'b0;

`ifdef MAT_DESER_DBUF_EN
    // Streaming with a free consumer: no input gaps, one pulse per matrix.
    out_ready   = 1'b1;
    pops_before = n_pops;
    for (int i = 0; i < 12; i++) begin
      check("dbuf_no_gap", in_ready, 1);
      feed(W'($urandom_range(0, 16'hffff)));
      if (i == 5 || i == 11) check("dbuf_pulse_hi", out_valid, 1);
      else                   check("dbuf_pulse_lo", out_valid, 0);
    end
    in_valid = 1'b0;
    wait_drain();
    check("dbuf_two_mats", 128'(n_pops - pops_before), 2);
    out_ready = 1'b0;
    @(negedge g.clk);

    // Stalled consumer: second matrix waits in the shadow.
    for (int i = 0; i < 12; i++) begin
      feed(W'($urandom_range(0, 16'hffff)));
      if (i == 5) mb1 = last_mat;
    end
    in_valid = 1'b0;
    check("dbuf_stall_in_ready", in_ready, 0);
    check("dbuf_stall_out_valid", out_valid, 1);
    check("dbuf_stall_f", f, mb1);
    out_ready = 1'b1;
    #1;
    check("dbuf_release_same_cycle", in_ready, 0);
    @(negedge g.clk);
    check("dbuf_recover_in_ready", in_ready, 1);
    check("dbuf_recover_out_valid", out_valid, 1);
    check("dbuf_recover_f", f, last_mat);
    wait_drain();
    out_ready = 1'b0;
`endif

    @(negedge g.clk);
    check("queue_empty", 128'(exp_q.size()), 0);
    report();
    $finish;
  end
endmodule
